// File: rtl/reg_bus_router_if.sv
// Upstream register bus: request fields from the master, rdata/ack back.
interface reg_bus_router_if #(
  parameter int AW = 11
);
  logic          reg_cs;
  logic          reg_wr;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wdata;
  logic [3:0]    reg_be;
  logic [31:0]   reg_rdata;
  logic          reg_ack;

  modport master (
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/reg_bus_router.sv
// Register-bus router: decodes an address field to one of NUM_TGT targets,
// registers the request toward the targets and returns a registered ack.
// Decode misses and ack watchdog expiries complete with ERR_RDATA and are
// recorded in a sticky error status.
module reg_bus_router #(
  parameter int                                      NUM_TGT   = 6,
  parameter int                                      AW        = 11,
  parameter int                                      SEL_MSB   = 10,
  parameter int                                      SEL_LSB   = 6,
  parameter logic [NUM_TGT*(SEL_MSB-SEL_LSB+1)-1:0] TGT_SEL   = '0,
  parameter logic [NUM_TGT*(SEL_MSB-SEL_LSB+1)-1:0] TGT_MASK  = '1,
  parameter int                                      TIMEOUT   = 255,
  parameter logic [31:0]                             ERR_RDATA = 32'hDEAD_DEAD
) (
  input  logic                  mclk,
  input  logic                  h_reset_n,
  reg_bus_router_if.slave       bus,
  output logic [NUM_TGT-1:0]    tgt_cs,
  output logic                  tgt_wr,
  output logic [AW-1:0]         tgt_addr,
  output logic [31:0]           tgt_wdata,
  output logic [3:0]            tgt_be,
  input  logic [NUM_TGT*32-1:0] tgt_rdata,
  input  logic [NUM_TGT-1:0]    tgt_ack,
  input  logic                  err_status_clr,
  output logic                  err_intr,
  output logic [1:0]            err_type,
  output logic                  err_ovf,
  output logic [AW-1:0]         err_addr
);
  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
  localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  // A disabled watchdog still needs a legal 1-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_intr_q, err_intr_d;
  logic [1:0]       err_type_q, err_type_d;
  logic             err_ovf_q, err_ovf_d;
  logic [AW-1:0]    err_addr_q, err_addr_d;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             sel_ack;
  logic [31:0]      sel_rdata;
  logic             err_ev;
  logic [1:0]       err_ev_type;
  logic [AW-1:0]    err_ev_addr;

  assign sel_ack   = tgt_ack[idx_q];
  assign sel_rdata = tgt_rdata[idx_q*32 +: 32];

  // Masked address decode; scanning downward lets the lowest hit win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (((bus.reg_addr[SEL_MSB:SEL_LSB] ^ TGT_SEL[i*SEL_W +: SEL_W]) &
           TGT_MASK[i*SEL_W +: SEL_W]) == '0) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Transaction FSM: request capture, ack/watchdog wait, one-cycle completion.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    cnt_d       = cnt_q;
    err_ev      = 1'b0;
    err_ev_type = '0;
    err_ev_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.reg_cs) begin
          if (hit) begin
            idx_d   = hit_idx;
            wr_d    = bus.reg_wr;
            addr_d  = bus.reg_addr;
            wdata_d = bus.reg_wdata;
            be_d    = bus.reg_be;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            rdata_d     = ERR_RDATA;
            ack_d       = 1'b1;
            err_ev      = 1'b1;
            err_ev_type = 2'b01;
            err_ev_addr = bus.reg_addr;
            state_d     = DONE;
          end
        end
      end
      ACCESS: begin
        if (sel_ack) begin
          rdata_d = sel_rdata;
          ack_d   = 1'b1;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d       = CNT_W'(TIMEOUT);
          rdata_d     = ERR_RDATA;
          ack_d       = 1'b1;
          err_ev      = 1'b1;
          err_ev_type = 2'b10;
          err_ev_addr = addr_q;
          state_d     = DONE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky error record; a clear makes room for an error in the same cycle.
  always_comb begin
    err_intr_d = err_intr_q;
    err_type_d = err_type_q;
    err_ovf_d  = err_ovf_q;
    err_addr_d = err_addr_q;
    if (err_status_clr) begin
      err_intr_d = 1'b0;
      err_type_d = '0;
      err_ovf_d  = 1'b0;
      err_addr_d = '0;
    end
    if (err_ev) begin
      if (!err_intr_d) begin
        err_intr_d = 1'b1;
        err_type_d = err_ev_type;
        err_addr_d = err_ev_addr;
      end else begin
        err_ovf_d = 1'b1;
      end
    end
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
      err_intr_q <= 1'b0;
      err_type_q <= '0;
      err_ovf_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
      err_intr_q <= err_intr_d;
      err_type_q <= err_type_d;
      err_ovf_q  <= err_ovf_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Select follows state directly so reset drops it without waiting a clock.
  assign tgt_cs        = (state_q == ACCESS) ? (NUM_TGT'(1) << idx_q) : '0;
  assign tgt_wr        = wr_q;
  assign tgt_addr      = addr_q;
  assign tgt_wdata     = wdata_q;
  assign tgt_be        = be_q;
  assign bus.reg_rdata = rdata_q;
  assign bus.reg_ack   = ack_q;
  assign err_intr      = err_intr_q;
  assign err_type      = err_type_q;
  assign err_ovf       = err_ovf_q;
  assign err_addr      = err_addr_q;
endmodule

// File: tb/tb_reg_bus_router.sv
// Scoreboard bench for reg_bus_router: stimulus pushes expected completions,
// a negedge monitor pops and compares on every reg_ack.
module tb_reg_bus_router;
  localparam int NT = 6;
  localparam int AW = 11;
  localparam int TO = 8;
  localparam logic [29:0] SEL_A = {5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00};
  localparam logic [29:0] SEL_B = {5'h05, 5'h04, 5'h13, 5'h02, 5'h01, 5'h10};
  localparam logic [29:0] MSK_B = {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h10};

  logic mclk = 1'b0;
  logic h_reset_n = 1'b1;
  always #5 mclk = ~mclk;

  reg_bus_router_if #(.AW(AW)) ifa ();
  reg_bus_router_if #(.AW(AW)) ifb ();

  logic          req_cs = 1'b0, req_wr = 1'b0, sel_b = 1'b0, clr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic [NT*32-1:0] t_rdata;
  logic [NT-1:0] resp_ack = '0, force_ack = '0;
  logic [NT-1:0] a_tgt_ack, b_tgt_ack;

  logic [NT-1:0] a_tgt_cs, b_tgt_cs;
  logic          a_tgt_wr, b_tgt_wr;
  logic [AW-1:0] a_tgt_addr, b_tgt_addr;
  logic [31:0]   a_tgt_wdata, b_tgt_wdata;
  logic [3:0]    a_tgt_be, b_tgt_be;
  logic          a_err_intr, b_err_intr, a_err_ovf, b_err_ovf;
  logic [1:0]    a_err_type, b_err_type;
  logic [AW-1:0] a_err_addr, b_err_addr;

  assign t_rdata = {32'h5555_0005, 32'h4444_0004, 32'h0B0B_0003,
                    32'h1234_5678, 32'hAAAA_5555, 32'h0B0B_0000};

  assign ifa.reg_cs = req_cs & ~sel_b;
  assign ifa.reg_wr = req_wr;
  assign ifa.reg_addr = req_addr;
  assign ifa.reg_wdata = req_wdata;
  assign ifa.reg_be = req_be;
  assign ifb.reg_cs = req_cs & sel_b;
  assign ifb.reg_wr = req_wr;
  assign ifb.reg_addr = req_addr;
  assign ifb.reg_wdata = req_wdata;
  assign ifb.reg_be = req_be;
  assign a_tgt_ack = sel_b ? '0 : (resp_ack | force_ack);
  assign b_tgt_ack = sel_b ? resp_ack : '0;

  reg_bus_router #(.NUM_TGT(NT), .AW(AW), .SEL_MSB(10), .SEL_LSB(6),
    .TGT_SEL(SEL_A), .TGT_MASK({30{1'b1}}), .TIMEOUT(TO)) u_a (
    .mclk(mclk), .h_reset_n(h_reset_n), .bus(ifa),
    .tgt_cs(a_tgt_cs), .tgt_wr(a_tgt_wr), .tgt_addr(a_tgt_addr),
    .tgt_wdata(a_tgt_wdata), .tgt_be(a_tgt_be), .tgt_rdata(t_rdata),
    .tgt_ack(a_tgt_ack), .err_status_clr(clr), .err_intr(a_err_intr),
    .err_type(a_err_type), .err_ovf(a_err_ovf), .err_addr(a_err_addr));

  reg_bus_router #(.NUM_TGT(NT), .AW(AW), .SEL_MSB(10), .SEL_LSB(6),
    .TGT_SEL(SEL_B), .TGT_MASK(MSK_B), .TIMEOUT(TO)) u_b (
    .mclk(mclk), .h_reset_n(h_reset_n), .bus(ifb),
    .tgt_cs(b_tgt_cs), .tgt_wr(b_tgt_wr), .tgt_addr(b_tgt_addr),
    .tgt_wdata(b_tgt_wdata), .tgt_be(b_tgt_be), .tgt_rdata(t_rdata),
    .tgt_ack(b_tgt_ack), .err_status_clr(clr), .err_intr(b_err_intr),
    .err_type(b_err_type), .err_ovf(b_err_ovf), .err_addr(b_err_addr));

  // Observed DUT is whichever one the stimulus currently addresses.
  logic          m_ack, m_intr, m_ovf;
  logic [31:0]   m_rdata;
  logic [NT-1:0] m_cs;
  logic [1:0]    m_type;
  logic [AW-1:0] m_eaddr;
  assign m_ack   = sel_b ? ifb.reg_ack   : ifa.reg_ack;
  assign m_rdata = sel_b ? ifb.reg_rdata : ifa.reg_rdata;
  assign m_cs    = sel_b ? b_tgt_cs      : a_tgt_cs;
  assign m_intr  = sel_b ? b_err_intr    : a_err_intr;
  assign m_type  = sel_b ? b_err_type    : a_err_type;
  assign m_ovf   = sel_b ? b_err_ovf     : a_err_ovf;
  assign m_eaddr = sel_b ? b_err_addr    : a_err_addr;

  typedef struct {
    logic [31:0]   rdata;
    logic [NT-1:0] cs;
    int            cs_cyc;
    int            lat;
    logic          intr;
    logic [1:0]    etype;
    logic          ovf;
    logic [AW-1:0] eaddr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic expect_txn(input logic [31:0] rd, input logic [NT-1:0] cs, input int cyc,
                            input int lat, input logic intr, input logic [1:0] et,
                            input logic ovf, input logic [AW-1:0] ea);
    exp_t e;
    e.rdata = rd; e.cs = cs; e.cs_cyc = cyc; e.lat = lat;
    e.intr = intr; e.etype = et; e.ovf = ovf; e.eaddr = ea;
    q.push_back(e);
  endtask

  // Target model: the selected target acks after ack_dly select cycles (-1 = never).
  int ack_dly = -1;
  int cs_cnt = 0;
  always @(negedge mclk) begin
    resp_ack = '0;
    if (m_cs != '0) begin
      if (ack_dly >= 0 && cs_cnt == ack_dly) resp_ack = m_cs;
      cs_cnt++;
    end else begin
      cs_cnt = 0;
    end
  end

  // Monitor: latency, select pattern and response compared on each ack.
  bit busy = 1'b0;
  int lat = 0;
  int cs_cyc = 0;
  logic [NT-1:0] cs_seen = '0;
  always @(negedge mclk) begin
    exp_t e;
    if (!h_reset_n) begin
      busy = 1'b0; lat = 0; cs_cyc = 0; cs_seen = '0;
    end else begin
      if (busy) lat++;
      else if (req_cs) begin busy = 1'b1; lat = 0; cs_cyc = 0; cs_seen = '0; end
      if (m_cs != '0) begin cs_cyc++; cs_seen = m_cs; end
      if (m_ack) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack rdata=%h", m_rdata);
        end else begin
          e = q.pop_front();
          chk("rdata", m_rdata, e.rdata);
          chk("tgt_cs", 32'(cs_seen), 32'(e.cs));
          chk("cs_cycles", cs_cyc, e.cs_cyc);
          chk("ack_latency", lat, e.lat);
          chk("err_intr", 32'(m_intr), 32'(e.intr));
          chk("err_type", 32'(m_type), 32'(e.etype));
          chk("err_ovf", 32'(m_ovf), 32'(e.ovf));
          chk("err_addr", 32'(m_eaddr), 32'(e.eaddr));
        end
        busy = 1'b0;
      end
    end
  end

  task automatic issue(input logic b, input logic wr, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input int dly);
    @(posedge mclk); #1;
    sel_b = b; ack_dly = dly; req_wr = wr; req_addr = addr;
    req_wdata = wd; req_be = be; req_cs = 1'b1;
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin @(posedge mclk); #1; n++; end while (!m_ack && n < 40);
    chk("ack_seen", 32'(m_ack), 32'd1);
    req_cs = 1'b0;
  endtask

  initial begin
    #2 h_reset_n = 1'b0;
    #1;
    chk("rst_ack", 32'(ifa.reg_ack), 32'd0);
    chk("rst_rdata", ifa.reg_rdata, 32'd0);
    chk("rst_tgt_cs", 32'(a_tgt_cs), 32'd0);
    chk("rst_tgt_addr", 32'(a_tgt_addr), 32'd0);
    chk("rst_err_intr", 32'(a_err_intr), 32'd0);
    chk("rst_err_type", 32'(a_err_type), 32'd0);
    repeat (3) @(posedge mclk);
    #1 h_reset_n = 1'b1;

    // Read target 2, ack on the 4th select cycle.
    expect_txn(32'h1234_5678, 6'b000100, 4, 5, 1'b0, 2'b00, 1'b0, '0);
    issue(1'b0, 1'b0, 11'h08C, 32'h0, 4'hF, 3);
    wait_ack();
    chk("tgt_addr_hit", 32'(a_tgt_addr), 32'h08C);
    chk("tgt_wr_hit", 32'(a_tgt_wr), 32'd0);

    // Unmapped write: decode error, tgt_* registers untouched.
    expect_txn(32'hDEAD_DEAD, '0, 0, 1, 1'b1, 2'b01, 1'b0, 11'h7C0);
    issue(1'b0, 1'b1, 11'h7C0, 32'hCAFE_0000, 4'hF, -1);
    wait_ack();
    chk("tgt_addr_hold", 32'(a_tgt_addr), 32'h08C);
    chk("tgt_wr_hold", 32'(a_tgt_wr), 32'd0);

    // Write to target 1 with immediate ack; write returns target rdata.
    expect_txn(32'hAAAA_5555, 6'b000010, 1, 2, 1'b1, 2'b01, 1'b0, 11'h7C0);
    issue(1'b0, 1'b1, 11'h05A, 32'hF00D_F00D, 4'h3, 0);
    wait_ack();
    chk("tgt_wdata", a_tgt_wdata, 32'hF00D_F00D);
    chk("tgt_be", 32'(a_tgt_be), 32'h3);
    chk("tgt_wr_write", 32'(a_tgt_wr), 32'd1);

    // Clear the error record.
    @(posedge mclk); #1 clr = 1'b1;
    @(posedge mclk); #1 clr = 1'b0;
    chk("clr_intr", 32'(a_err_intr), 32'd0);
    chk("clr_addr", 32'(a_err_addr), 32'd0);
    chk("clr_type", 32'(a_err_type), 32'd0);

    // Timeout on target 4, then a late ack that must be ignored.
    expect_txn(32'hDEAD_DEAD, 6'b010000, TO, TO + 1, 1'b1, 2'b10, 1'b0, 11'h103);
    issue(1'b0, 1'b0, 11'h103, 32'h0, 4'hF, -1);
    wait_ack();
    repeat (2) @(posedge mclk);
    #1 force_ack = 6'b010000;
    @(posedge mclk); #1 force_ack = '0;
    repeat (3) @(posedge mclk);
    chk("late_ack_no_ovf", 32'(a_err_ovf), 32'd0);

    // Second error while interrupt pending: overflow only.
    expect_txn(32'hDEAD_DEAD, '0, 0, 1, 1'b1, 2'b10, 1'b1, 11'h103);
    issue(1'b0, 1'b0, 11'h7FF, 32'h0, 4'hF, -1);
    wait_ack();

    // Clear coincident with a third error: fresh record holds the new error.
    expect_txn(32'hDEAD_DEAD, '0, 0, 1, 1'b1, 2'b01, 1'b0, 11'h7A5);
    issue(1'b0, 1'b1, 11'h7A5, 32'h0, 4'hF, -1);
    clr = 1'b1;
    wait_ack();
    clr = 1'b0;

    // Reset in the middle of an access to target 5.
    issue(1'b0, 1'b0, 11'h140, 32'h0, 4'hF, -1);
    repeat (3) @(posedge mclk);
    #1 h_reset_n = 1'b0;
    req_cs = 1'b0;
    #1;
    chk("midrst_tgt_cs", 32'(a_tgt_cs), 32'd0);
    chk("midrst_ack", 32'(ifa.reg_ack), 32'd0);
    chk("midrst_rdata", ifa.reg_rdata, 32'd0);
    chk("midrst_err_intr", 32'(a_err_intr), 32'd0);
    chk("midrst_tgt_addr", 32'(a_tgt_addr), 32'd0);
    @(posedge mclk); #1 h_reset_n = 1'b1;

    // Normal read of target 3 after reset.
    expect_txn(32'h0B0B_0003, 6'b001000, 2, 3, 1'b0, 2'b00, 1'b0, '0);
    issue(1'b0, 1'b0, 11'h0D1, 32'h0, 4'hF, 1);
    wait_ack();

    // Overlapping decode on the second router: target 0 wins over exact target 3.
    expect_txn(32'h0B0B_0000, 6'b000001, 2, 3, 1'b0, 2'b00, 1'b0, '0);
    issue(1'b1, 1'b0, 11'h4C0, 32'h0, 4'hF, 1);
    wait_ack();

    repeat (3) @(posedge mclk);
    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/reg_bus_router.md
# reg_bus_router

Parametrised register-bus router for the pinmux/peripheral subsystem. It takes one upstream register bus and decodes a configurable address field to select one of NUM_TGT targets. The selected request is registered and broadcast to all targets, and the selected response is returned with a registered ack. A per-transaction ack watchdog and an unmapped-address decoder complete every access with an error response, and record the error in a sticky error status with an interrupt.

## Interface
Parameters:
- NUM_TGT, 6: number of targets (1..16).
- AW, 11: address width.
- SEL_MSB, 10 / SEL_LSB, 6: address bit field used for decode. SEL_W = SEL_MSB-SEL_LSB+1.
- TGT_SEL, {NUM_TGT{SEL_W'h0}} packed: match value of target i, in bits [i*SEL_W +: SEL_W].
- TGT_MASK, all ones, packed: per-target compare mask. A mask bit of 0 means don't-care.
- TIMEOUT, 255: maximum number of ACCESS cycles without an ack. 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_DEAD: rdata returned on an error.

Ports:
- mclk  in  1  system clock; the only clock.
- h_reset_n  in  1  asynchronous active-low reset.
- reg_cs, reg_wr  in  1  upstream request and write flag.
- reg_addr  in  AW  upstream address.
- reg_wdata  in  32  upstream write data.
- reg_be  in  4  upstream byte enables.
- reg_rdata  out  32  response data.
- reg_ack  out  1  single-cycle completion pulse.
- tgt_cs  out  NUM_TGT  one-hot target select.
- tgt_wr  out  1  registered copy of reg_wr.
- tgt_addr  out  AW  registered copy of reg_addr.
- tgt_wdata  out  32  registered copy of reg_wdata.
- tgt_be  out  4  registered copy of reg_be.
- tgt_rdata  in  NUM_TGT*32  target read data; target i occupies [i*32 +: 32].
- tgt_ack  in  NUM_TGT  target acks.
- err_status_clr  in  1  clears the error status.
- err_intr  out  1  sticky error interrupt.
- err_type  out  2  01 = decode miss, 10 = timeout.
- err_ovf  out  1  a further error occurred while err_intr was set.
- err_addr  out  AW  address of the first captured error.

## Operation
- Decode: target i hits when ((reg_addr[SEL_MSB:SEL_LSB] ^ TGT_SEL_i) & TGT_MASK_i) == 0. The lowest index wins on multiple hits.
- The FSM has three states: IDLE, ACCESS, DONE.
- IDLE, reg_cs=1 with a hit:
  - latch the target index, reg_wr, reg_addr, reg_wdata and reg_be into the tgt_* registers;
  - clear the watchdog counter;
  - go to ACCESS.
- IDLE, reg_cs=1 with no hit: load reg_rdata=ERR_RDATA, record a decode error, go to DONE. No tgt_cs is asserted.
- ACCESS:
  - tgt_cs[idx]=1, decoded combinationally from state and idx.
  - When tgt_ack[idx]=1: load reg_rdata=tgt_rdata[idx] for both reads and writes, go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT: load ERR_RDATA, record a timeout error, go to DONE.
  - Acks from non-selected targets are ignored.
- DONE: reg_ack=1 for exactly this cycle, then go to IDLE. Upstream request inputs are ignored in DONE.
- Late acks, arriving outside ACCESS or after a timeout, are ignored.
- If reg_cs drops during ACCESS, the transaction still completes and reg_ack still pulses.
- The tgt_* request registers hold their value between transactions.
- Error record:
  - If err_intr=0: latch err_addr from the request address, set err_type, set err_intr=1.
  - If err_intr=1: set err_ovf only; err_addr and err_type are unchanged.
  - err_status_clr=1 clears err_intr, err_type, err_ovf and err_addr to 0.
  - If a clear and an error occur in the same cycle, the new error is captured into the freshly cleared record (err_ovf=0).

## Timing
- Every register resets to 0 asynchronously: state IDLE, reg_rdata, reg_ack, tgt_cs, tgt_wr, tgt_addr, tgt_wdata, tgt_be, counter and all err_* outputs.
- Hit path:
  - reg_cs sampled at cycle T;
  - tgt_cs asserted from T+1;
  - target ack in cycle T+1+k;
  - tgt_cs deasserts at T+2+k;
  - reg_ack=1 in cycle T+2+k.
- Miss path: reg_cs sampled at T, reg_ack at T+1.
- Timeout path: tgt_cs is high for exactly TIMEOUT cycles, and reg_ack follows the next cycle.
- reg_rdata is valid in the reg_ack cycle and holds until the next completion.
- Back-to-back: the master may present the next reg_cs in the cycle after reg_ack (IDLE). The hit-path throughput is one transfer per k+3 cycles.
- Upstream protocol: the master holds the request fields stable from reg_cs assertion until reg_ack.
- Watchdog counter width is $clog2(TIMEOUT+1). It saturates in the timeout cycle and never wraps.
- Reset asserted mid-ACCESS: tgt_cs and reg_ack drop immediately and no ack is generated.

## Test plan
- Read from target 2 with SEL=5'h02, target acks after 3 cycles with rdata 32'h1234_5678 -> tgt_cs=6'b000100 for 4 cycles; reg_ack one cycle later with rdata 32'h1234_5678; err_intr=0.
- Write to an unmapped address 11'h7C0 -> no tgt_cs; reg_ack at T+1; rdata 32'hDEAD_DEAD; err_type=01; err_addr=11'h7C0; err_intr=1.
- TIMEOUT=8, target never acks -> tgt_cs high for 8 cycles; reg_ack with ERR_RDATA; err_type=10. A target ack arriving 2 cycles later is ignored, with no extra reg_ack.
- Second error while err_intr=1 -> err_ovf=1 and err_addr unchanged. err_status_clr in the same cycle as a third error -> err_intr=1, err_ovf=0, err_addr = the third error's address.
- Overlapping masks: target 0 mask 5'h10 with SEL 5'h10, and target 3 exact 5'h13; access 5'h13 -> target 0 selected (lowest index wins).
- Assert h_reset_n low during ACCESS -> all outputs 0 immediately. After release, a new read completes normally.
